mic_frame_buffer: RTL and testbench

Sits between get_microphone_samples and the N-point FFT. Runs entirely in the adc_clk domain. Turns the microphone sample stream into complete, double-buffered frames of N_POINTS samples, each with the offset removed. Presents one frame at a time through a valid/ready handshake, so the FFT loader never sees a frame that is still filling; frames that arrive while the output is still held are counted as overruns.

---
 rtl/mic_frame_buffer.sv | 135 +++++++++++++
 tb/tb_mic_frame_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_frame_buffer.sv
`default_nettype none
// ============================================================================
// mic_frame_buffer : decimates and offset-corrects microphone samples into
//                    double-buffered N_POINTS frames behind a valid/ready port
// Revision: 1.0
// ============================================================================
module mic_frame_buffer #(
   parameter int SAMPLE_W      = 32,
   parameter int N_POINTS      = 8,
   parameter int DECIM         = 1,
   parameter int SAMPLE_OFFSET = 0,
   parameter int OVR_W         = 8
) (
   input  logic                         adc_clk,
   input  logic                         reset,
   input  logic [SAMPLE_W-1:0]          sample_in,
   input  logic                         sample_valid,
   output logic [N_POINTS*SAMPLE_W-1:0] frame_data,
   output logic                         frame_valid,
   input  logic                         frame_ready,
   output logic [7:0]                   frame_seq,
   output logic                         overrun,
   output logic [OVR_W-1:0]             overrun_count
);

   localparam int                  c_IDX_W    = $clog2(N_POINTS);
   localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(N_POINTS - 1);
   localparam logic [7:0]          c_DEC_LAST = 8'(DECIM - 1);
   localparam logic [SAMPLE_W-1:0] c_OFFSET   = SAMPLE_W'(SAMPLE_OFFSET);

   typedef enum logic [0:0] {
      S_FILL = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t                         r_state;
   state_t                         w_state_next;
   logic [7:0]                     r_dec_cnt;
   logic [c_IDX_W-1:0]             r_fill_idx;
   logic [SAMPLE_W-1:0]            r_fill [N_POINTS];
   logic [N_POINTS*SAMPLE_W-1:0]   r_frame_data;
   logic [7:0]                     r_frame_seq;
   logic                           r_overrun;
   logic [OVR_W-1:0]               r_ovr_cnt;

   logic                           w_accept;
   logic [SAMPLE_W-1:0]            w_sample;
   logic                           w_complete;
   logic                           w_transfer;
   logic                           w_load;
   logic                           w_drop;
   logic [N_POINTS*SAMPLE_W-1:0]   w_next_frame;

   assign w_accept   = sample_valid && (r_dec_cnt == 8'd0);
   assign w_sample   = sample_in - c_OFFSET;
   assign w_complete = w_accept && (r_fill_idx == c_LAST_IDX);
   assign w_transfer = (r_state == S_HOLD) && frame_ready;
   // A transfer on the completing edge frees the output, so the new frame loads instead of dropping
   assign w_load     = w_complete && ((r_state == S_FILL) || w_transfer);
   assign w_drop     = w_complete && (r_state == S_HOLD) && !frame_ready;

   // The last slice comes straight from the input: it is written on the same edge the frame is copied
   for (genvar k = 0; k < N_POINTS; k++) begin : g_slice
      if (k == N_POINTS - 1) begin : g_last
         assign w_next_frame[k*SAMPLE_W +: SAMPLE_W] = w_sample;
      end else begin : g_stored
         assign w_next_frame[k*SAMPLE_W +: SAMPLE_W] = r_fill[k];
      end
   end

   always_ff @(posedge adc_clk) begin
      if (reset) begin
         r_dec_cnt <= 8'd0;
      end else if (sample_valid) begin
         r_dec_cnt <= (r_dec_cnt == c_DEC_LAST) ? 8'd0 : r_dec_cnt + 8'd1;
      end
   end

   always_ff @(posedge adc_clk) begin
      if (reset) begin
         r_fill_idx <= '0;
      end else if (w_accept) begin
         r_fill_idx <= r_fill_idx + c_IDX_W'(1);
      end
   end

   always_ff @(posedge adc_clk) begin
      if (w_accept) begin
         r_fill[r_fill_idx] <= w_sample;
      end
   end

   always_ff @(posedge adc_clk) begin
      if (reset) begin
         r_frame_data <= '0;
         r_frame_seq  <= 8'd0;
         r_overrun    <= 1'b0;
         r_ovr_cnt    <= '0;
      end else begin
         r_overrun <= w_drop;
         if (w_load) begin
            r_frame_data <= w_next_frame;
            r_frame_seq  <= r_frame_seq + 8'd1;
         end
         if (w_drop && (r_ovr_cnt != {OVR_W{1'b1}})) begin
            r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
         end
      end
   end

   always_ff @(posedge adc_clk) begin
      if (reset) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FILL: if (w_complete) w_state_next = S_HOLD;
         S_HOLD: if (w_transfer && !w_complete) w_state_next = S_FILL;
         default: w_state_next = S_FILL;
      endcase
   end

   assign frame_data    = r_frame_data;
   assign frame_valid   = (r_state == S_HOLD);
   assign frame_seq     = r_frame_seq;
   assign overrun       = r_overrun;
   assign overrun_count = r_ovr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mic_frame_buffer.sv
`default_nettype none
// ============================================================================
// tb_mic_frame_buffer : directed-vector bench for mic_frame_buffer
// Revision: 1.0
// ============================================================================
module tb_mic_frame_buffer;

   logic          adc_clk = 1'b0;
   logic          reset   = 1'b1;

   logic [31:0]   a_sample_in = '0;
   logic          a_valid     = 1'b0;
   logic          a_ready     = 1'b0;
   logic [255:0]  a_frame_data;
   logic          a_frame_valid;
   logic [7:0]    a_frame_seq;
   logic          a_overrun;
   logic [7:0]    a_ovr_cnt;

   logic [31:0]   b_sample_in = '0;
   logic          b_valid     = 1'b0;
   logic          b_ready     = 1'b0;
   logic [255:0]  b_frame_data;
   logic          b_frame_valid;
   logic [7:0]    b_frame_seq;
   logic          b_overrun;
   logic [7:0]    b_ovr_cnt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 adc_clk = ~adc_clk;

   mic_frame_buffer u_dut_a (
      .adc_clk       (adc_clk),
      .reset         (reset),
      .sample_in     (a_sample_in),
      .sample_valid  (a_valid),
      .frame_data    (a_frame_data),
      .frame_valid   (a_frame_valid),
      .frame_ready   (a_ready),
      .frame_seq     (a_frame_seq),
      .overrun       (a_overrun),
      .overrun_count (a_ovr_cnt)
   );

   mic_frame_buffer #(
      .DECIM         (2),
      .SAMPLE_OFFSET (2048)
   ) u_dut_b (
      .adc_clk       (adc_clk),
      .reset         (reset),
      .sample_in     (b_sample_in),
      .sample_valid  (b_valid),
      .frame_data    (b_frame_data),
      .frame_valid   (b_frame_valid),
      .frame_ready   (b_ready),
      .frame_seq     (b_frame_seq),
      .overrun       (b_overrun),
      .overrun_count (b_ovr_cnt)
   );

   task automatic tick();
      @(posedge adc_clk);
      #1;
   endtask

   task automatic feed_a(input logic [31:0] s, input logic rdy);
      a_sample_in = s;
      a_valid     = 1'b1;
      a_ready     = rdy;
      tick();
      a_valid     = 1'b0;
      a_ready     = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_valid = 1'b1; a_sample_in = 32'd99;
      b_valid = 1'b1; b_sample_in = 32'd99;
      tick();
      tick();
      vectors++;
      if ({a_frame_valid, a_frame_data, a_frame_seq, a_overrun, a_ovr_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_a: got valid=%0b seq=%0d ovr=%0b cnt=%0d data=%h, want all 0",
                  a_frame_valid, a_frame_seq, a_overrun, a_ovr_cnt, a_frame_data);
      end
      vectors++;
      if ({b_frame_valid, b_frame_data, b_frame_seq, b_overrun, b_ovr_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_b: got valid=%0b seq=%0d ovr=%0b cnt=%0d, want all 0",
                  b_frame_valid, b_frame_seq, b_overrun, b_ovr_cnt);
      end
      reset = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic test_basic_frame();
      for (int i = 1; i <= 8; i++) begin
         feed_a(32'(i), 1'b0);
         if (i == 7) begin
            vectors++;
            if (a_frame_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL basic_early_valid: got %0b, want 0 after 7 samples", a_frame_valid);
            end
         end
      end
      vectors++;
      if (a_frame_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_valid: got %0b, want 1", a_frame_valid);
      end
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (a_frame_data[k*32 +: 32] !== 32'(k + 1)) begin
            miscompares++;
            $display("FAIL basic_slice%0d: got %0d, want %0d", k, a_frame_data[k*32 +: 32], k + 1);
         end
      end
      vectors++;
      if (a_frame_seq !== 8'd1) begin
         miscompares++;
         $display("FAIL basic_seq: got %0d, want 1", a_frame_seq);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 9; i <= 16; i++) begin
         feed_a(32'(i), (i == 16));
      end
      vectors++;
      if (a_frame_valid !== 1'b1 || a_frame_seq !== 8'd2 || a_overrun !== 1'b0 || a_ovr_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL b2b_status: got valid=%0b seq=%0d ovr=%0b cnt=%0d, want 1/2/0/0",
                  a_frame_valid, a_frame_seq, a_overrun, a_ovr_cnt);
      end
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (a_frame_data[k*32 +: 32] !== 32'(k + 9)) begin
            miscompares++;
            $display("FAIL b2b_slice%0d: got %0d, want %0d", k, a_frame_data[k*32 +: 32], k + 9);
         end
      end
   endtask

   task automatic test_overrun();
      int pulses;
      do_reset();
      pulses = 0;
      for (int i = 1; i <= 24; i++) begin
         feed_a(32'(i), 1'b0);
         if (a_overrun === 1'b1) pulses++;
         if (i == 17) begin
            vectors++;
            if (a_overrun !== 1'b0) begin
               miscompares++;
               $display("FAIL ovr_pulse_width: got %0b, want 0 one cycle after drop", a_overrun);
            end
         end
      end
      vectors++;
      if (pulses != 2 || a_ovr_cnt !== 8'd2 || a_frame_seq !== 8'd1 || a_frame_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_status: got pulses=%0d cnt=%0d seq=%0d valid=%0b, want 2/2/1/1",
                  pulses, a_ovr_cnt, a_frame_seq, a_frame_valid);
      end
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (a_frame_data[k*32 +: 32] !== 32'(k + 1)) begin
            miscompares++;
            $display("FAIL ovr_held_slice%0d: got %0d, want %0d", k, a_frame_data[k*32 +: 32], k + 1);
         end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 8 * 260; i++) begin
         feed_a(32'(i), 1'b0);
      end
      vectors++;
      if (a_ovr_cnt !== 8'hFF || a_frame_seq !== 8'd1 || a_frame_data[31:0] !== 32'd1) begin
         miscompares++;
         $display("FAIL ovr_saturate: got cnt=%0d seq=%0d slice0=%0d, want 255/1/1",
                  a_ovr_cnt, a_frame_seq, a_frame_data[31:0]);
      end
   endtask

   task automatic test_handshake();
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      vectors++;
      if (a_frame_valid !== 1'b0 || a_overrun !== 1'b0 || a_frame_seq !== 8'd1) begin
         miscompares++;
         $display("FAIL handshake_release: got valid=%0b ovr=%0b seq=%0d, want 0/0/1",
                  a_frame_valid, a_overrun, a_frame_seq);
      end
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      vectors++;
      if (a_frame_valid !== 1'b0 || a_frame_seq !== 8'd1) begin
         miscompares++;
         $display("FAIL handshake_idle_ready: got valid=%0b seq=%0d, want 0/1", a_frame_valid, a_frame_seq);
      end
   endtask

   task automatic test_mid_frame_reset();
      do_reset();
      for (int i = 0; i < 5; i++) feed_a(32'(100 + i), 1'b0);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         feed_a(32'(201 + i), 1'b0);
         if (i == 2) begin
            vectors++;
            if (a_frame_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL midrst_early_valid: got %0b, want 0", a_frame_valid);
            end
         end
      end
      vectors++;
      if (a_frame_valid !== 1'b1 || a_frame_seq !== 8'd1) begin
         miscompares++;
         $display("FAIL midrst_status: got valid=%0b seq=%0d, want 1/1", a_frame_valid, a_frame_seq);
      end
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (a_frame_data[k*32 +: 32] !== 32'(201 + k)) begin
            miscompares++;
            $display("FAIL midrst_slice%0d: got %0d, want %0d", k, a_frame_data[k*32 +: 32], 201 + k);
         end
      end
   endtask

   task automatic test_offset_decim();
      logic [31:0] stim [16];
      logic [31:0] exp_v [8];
      stim = '{32'd2048, 32'd0, 32'd2049, 32'd0, 32'd2047, 32'd0, 32'd2050, 32'd0,
               32'd2046, 32'd0, 32'd2051, 32'd0, 32'd2045, 32'd0, 32'd2052, 32'd0};
      exp_v = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002,
                32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFD, 32'h0000_0004};
      for (int i = 0; i < 16; i++) begin
         b_sample_in = stim[i];
         b_valid     = 1'b1;
         tick();
         b_valid     = 1'b0;
         // idle gap must not disturb decimation phase or fill index
         if (i == 5) tick();
         if (i == 13) begin
            vectors++;
            if (b_frame_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL decim_early_valid: got %0b, want 0", b_frame_valid);
            end
         end
      end
      vectors++;
      if (b_frame_valid !== 1'b1 || b_frame_seq !== 8'd1) begin
         miscompares++;
         $display("FAIL decim_status: got valid=%0b seq=%0d, want 1/1", b_frame_valid, b_frame_seq);
      end
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (b_frame_data[k*32 +: 32] !== exp_v[k]) begin
            miscompares++;
            $display("FAIL decim_slice%0d: got %h, want %h", k, b_frame_data[k*32 +: 32], exp_v[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_overrun();
      test_saturation();
      test_handshake();
      test_mid_frame_reset();
      test_offset_decim();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
